// File: rtl/ccip_host_mem_responder.sv
// CCI-P host memory responder: serves c0 read-line and c1 write-line requests
// from a local line memory and returns in-order responses with mdata echoed.

module ccip_rsp_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 16,
   parameter int SLACK = 4
)(
   input  logic         clk,
   input  logic         reset_n,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pend_nxt,
   input  logic         stall,
   output logic         rsp_valid,
   output logic [W-1:0] rsp_data,
   output logic         alm_full,
   output logic         ovf
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL   = CNT_W'(DEPTH);
   localparam logic [CNT_W:0]   THRESH = (CNT_W+1)'(DEPTH - SLACK);

   logic [W-1:0]     store [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count, count_nxt;
   logic             push_ok, pop;

   // pop only looks at the current count, so a push into an empty FIFO waits a cycle
   always_comb begin
      push_ok   = push && (count != FULL);
      pop       = !stall && (count != '0);
      count_nxt = count;
      if (push_ok && !pop)
         count_nxt = count + CNT_W'(1);
      else if (!push_ok && pop)
         count_nxt = count - CNT_W'(1);
   end

   always_ff @(posedge clk)
      if (push_ok) store[wr_ptr] <= push_data;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         alm_full  <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
         count     <= count_nxt;
         rsp_valid <= pop;
         if (pop) rsp_data <= store[rd_ptr];
         // pend_nxt counts a read that has been accepted but not yet pushed
         alm_full  <= ({1'b0, count_nxt} + {{CNT_W{1'b0}}, pend_nxt}) >= THRESH;
         if (push && !push_ok) ovf <= 1'b1;
      end
   end
endmodule

module ccip_host_mem_responder #(
   parameter int ADDR_W        = 10,
   parameter int FIFO_DEPTH    = 16,
   parameter int ALMFULL_SLACK = 4
)(
   input  logic         clk,
   input  logic         reset_n,
   input  logic         c0_req_valid,
   input  logic [41:0]  c0_req_addr,
   input  logic [15:0]  c0_req_mdata,
   input  logic         c1_req_valid,
   input  logic [41:0]  c1_req_addr,
   input  logic [15:0]  c1_req_mdata,
   input  logic [511:0] c1_req_data,
   input  logic         rsp_stall,
   output logic         c0TxAlmFull,
   output logic         c1TxAlmFull,
   output logic         c0_rsp_valid,
   output logic [3:0]   c0_rsp_type,
   output logic [15:0]  c0_rsp_mdata,
   output logic [511:0] c0_rsp_data,
   output logic         c1_rsp_valid,
   output logic [3:0]   c1_rsp_type,
   output logic [15:0]  c1_rsp_mdata,
   output logic         overflow_err
);
   localparam logic [3:0] RSP_RDLINE = 4'h0;
   localparam logic [3:0] RSP_WRLINE = 4'h1;

   logic [511:0]      mem [2**ADDR_W];
   logic [ADDR_W-1:0] rd_idx, wr_idx;
   logic              rd_pend_vld;
   logic [15:0]       rd_pend_mdata;
   logic [511:0]      rd_pend_data;
   logic [527:0]      c0_rsp_word;
   logic              c0_ovf, c1_ovf;
   logic              unused_addr_hi;

   // upper address bits are ignored on purpose: lines alias modulo the memory depth
   assign rd_idx         = c0_req_addr[ADDR_W-1:0];
   assign wr_idx         = c1_req_addr[ADDR_W-1:0];
   assign unused_addr_hi = ^{c0_req_addr[41:ADDR_W], c1_req_addr[41:ADDR_W]};

   // nonblocking read of mem gives read-before-write for same-cycle collisions
   always_ff @(posedge clk) begin
      if (c1_req_valid) mem[wr_idx] <= c1_req_data;
      if (c0_req_valid) rd_pend_data <= mem[rd_idx];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_pend_vld   <= 1'b0;
         rd_pend_mdata <= '0;
         c1_rsp_type   <= 4'h0;
      end else begin
         rd_pend_vld   <= c0_req_valid;
         if (c0_req_valid) rd_pend_mdata <= c0_req_mdata;
         c1_rsp_type   <= RSP_WRLINE;
      end
   end

   ccip_rsp_fifo #(.W(528), .DEPTH(FIFO_DEPTH), .SLACK(ALMFULL_SLACK)) u_c0_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (rd_pend_vld),
      .push_data ({rd_pend_mdata, rd_pend_data}),
      .pend_nxt  (c0_req_valid),
      .stall     (rsp_stall),
      .rsp_valid (c0_rsp_valid),
      .rsp_data  (c0_rsp_word),
      .alm_full  (c0TxAlmFull),
      .ovf       (c0_ovf)
   );

   ccip_rsp_fifo #(.W(16), .DEPTH(FIFO_DEPTH), .SLACK(ALMFULL_SLACK)) u_c1_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .push      (c1_req_valid),
      .push_data (c1_req_mdata),
      .pend_nxt  (1'b0),
      .stall     (rsp_stall),
      .rsp_valid (c1_rsp_valid),
      .rsp_data  (c1_rsp_mdata),
      .alm_full  (c1TxAlmFull),
      .ovf       (c1_ovf)
   );

   assign c0_rsp_mdata = c0_rsp_word[527:512];
   assign c0_rsp_data  = c0_rsp_word[511:0];
   assign c0_rsp_type  = RSP_RDLINE;
   assign overflow_err = c0_ovf | c1_ovf;
endmodule

// File: tb/tb_ccip_host_mem_responder.sv
// Scoreboard bench for ccip_host_mem_responder: expectations are queued when
// requests are driven and consumed by a response monitor.

module tb_ccip_host_mem_responder;
   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         c0_req_valid = 1'b0;
   logic [41:0]  c0_req_addr = '0;
   logic [15:0]  c0_req_mdata = '0;
   logic         c1_req_valid = 1'b0;
   logic [41:0]  c1_req_addr = '0;
   logic [15:0]  c1_req_mdata = '0;
   logic [511:0] c1_req_data = '0;
   logic         rsp_stall = 1'b0;
   logic         c0TxAlmFull, c1TxAlmFull;
   logic         c0_rsp_valid, c1_rsp_valid;
   logic [3:0]   c0_rsp_type, c1_rsp_type;
   logic [15:0]  c0_rsp_mdata, c1_rsp_mdata;
   logic [511:0] c0_rsp_data;
   logic         overflow_err;

   typedef struct packed {
      logic [15:0]  md;
      logic [511:0] d;
   } exp0_t;

   exp0_t        exp0[$];
   logic [15:0]  exp1[$];
   logic [511:0] mdl [int];
   int checks = 0, failures = 0;
   int rsp0_cnt = 0, rsp1_cnt = 0;

   localparam logic [511:0] PAT_A5 = {64{8'hA5}};

   ccip_host_mem_responder dut (
      .clk(clk), .reset_n(reset_n),
      .c0_req_valid(c0_req_valid), .c0_req_addr(c0_req_addr), .c0_req_mdata(c0_req_mdata),
      .c1_req_valid(c1_req_valid), .c1_req_addr(c1_req_addr), .c1_req_mdata(c1_req_mdata),
      .c1_req_data(c1_req_data), .rsp_stall(rsp_stall),
      .c0TxAlmFull(c0TxAlmFull), .c1TxAlmFull(c1TxAlmFull),
      .c0_rsp_valid(c0_rsp_valid), .c0_rsp_type(c0_rsp_type),
      .c0_rsp_mdata(c0_rsp_mdata), .c0_rsp_data(c0_rsp_data),
      .c1_rsp_valid(c1_rsp_valid), .c1_rsp_type(c1_rsp_type),
      .c1_rsp_mdata(c1_rsp_mdata), .overflow_err(overflow_err)
   );

   always #5 clk = ~clk;

   // response monitor: samples on the falling edge
   always @(negedge clk) begin
      if (reset_n) begin
         if (c0_rsp_valid) begin
            exp0_t e;
            rsp0_cnt++;
            checks++;
            if (exp0.size() == 0) begin
               failures++;
               $display("FAIL c0_unexpected got md=%h, none expected", c0_rsp_mdata);
            end else begin
               e = exp0.pop_front();
               if ({c0_rsp_type, c0_rsp_mdata, c0_rsp_data} !== {4'h0, e.md, e.d}) begin
                  failures++;
                  $display("FAIL c0_rsp got type=%h md=%h d=%h exp type=0 md=%h d=%h",
                           c0_rsp_type, c0_rsp_mdata, c0_rsp_data, e.md, e.d);
               end
            end
         end
         if (c1_rsp_valid) begin
            logic [15:0] m;
            rsp1_cnt++;
            checks++;
            if (exp1.size() == 0) begin
               failures++;
               $display("FAIL c1_unexpected got md=%h, none expected", c1_rsp_mdata);
            end else begin
               m = exp1.pop_front();
               if ({c1_rsp_type, c1_rsp_mdata} !== {4'h1, m}) begin
                  failures++;
                  $display("FAIL c1_rsp got type=%h md=%h exp type=1 md=%h",
                           c1_rsp_type, c1_rsp_mdata, m);
               end
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // one request cycle; read expectation is taken from the model before the write lands
   task automatic issue(input bit do_rd, input logic [41:0] ra, input logic [15:0] rmd,
                        input bit exp_rd, input bit do_wr, input logic [41:0] wa,
                        input logic [15:0] wmd, input logic [511:0] wd);
      exp0_t e;
      logic [9:0] ri, wi;
      ri = ra[9:0];
      wi = wa[9:0];
      c0_req_valid = do_rd; c0_req_addr = ra; c0_req_mdata = rmd;
      c1_req_valid = do_wr; c1_req_addr = wa; c1_req_mdata = wmd; c1_req_data = wd;
      if (do_rd && exp_rd) begin
         e.md = rmd;
         e.d  = mdl[int'(ri)];
         exp0.push_back(e);
      end
      if (do_wr) begin
         mdl[int'(wi)] = wd;
         exp1.push_back(wmd);
      end
      cyc();
      c0_req_valid = 1'b0;
      c1_req_valid = 1'b0;
   endtask

   task automatic rd(input logic [41:0] a, input logic [15:0] md, input bit exp_rd);
      issue(1'b1, a, md, exp_rd, 1'b0, '0, '0, '0);
   endtask

   task automatic wr(input logic [41:0] a, input logic [15:0] md, input logic [511:0] d);
      issue(1'b0, '0, '0, 1'b0, 1'b1, a, md, d);
   endtask

   task automatic drain(input int max_cyc, input string name);
      for (int i = 0; i < max_cyc && (exp0.size() != 0 || exp1.size() != 0); i++) cyc();
      repeat (3) cyc();
      checks++;
      if (exp0.size() != 0 || exp1.size() != 0) begin
         failures++;
         $display("FAIL %s_drain pending c0=%0d c1=%0d required 0/0", name, exp0.size(), exp1.size());
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({c0TxAlmFull, c1TxAlmFull, c0_rsp_valid, c0_rsp_type, c0_rsp_mdata, c0_rsp_data,
           c1_rsp_valid, c1_rsp_type, c1_rsp_mdata, overflow_err} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got v0=%b v1=%b t1=%h md0=%h md1=%h af=%b%b ovf=%b required all 0",
                  c0_rsp_valid, c1_rsp_valid, c1_rsp_type, c0_rsp_mdata, c1_rsp_mdata,
                  c0TxAlmFull, c1TxAlmFull, overflow_err);
      end
      repeat (2) cyc();
      reset_n = 1'b1;
      repeat (2) cyc();
   endtask

   task automatic test_basic();
      wr(42'h10, 16'h0007, PAT_A5);
      checks++;
      if (c1_rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL wr_latency_early c1_rsp_valid=%b required 0", c1_rsp_valid);
      end
      cyc();
      checks++;
      if ({c1_rsp_valid, c1_rsp_mdata} !== {1'b1, 16'h0007}) begin
         failures++;
         $display("FAIL wr_latency got v=%b md=%h required v=1 md=0007", c1_rsp_valid, c1_rsp_mdata);
      end
      drain(10, "basic_wr");
      rd(42'h10, 16'h0033, 1'b1);
      cyc();
      checks++;
      if (c0_rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL rd_latency_early c0_rsp_valid=%b required 0", c0_rsp_valid);
      end
      cyc();
      checks++;
      if ({c0_rsp_valid, c0_rsp_mdata, c0_rsp_data} !== {1'b1, 16'h0033, PAT_A5}) begin
         failures++;
         $display("FAIL rd_latency got v=%b md=%h d=%h required v=1 md=0033 d=a5..a5",
                  c0_rsp_valid, c0_rsp_mdata, c0_rsp_data);
      end
      drain(10, "basic_rd");
   endtask

   task automatic test_same_cycle();
      wr(42'h20, 16'h0040, 512'h1);
      drain(10, "collide_pre");
      issue(1'b1, 42'h20, 16'h0041, 1'b1, 1'b1, 42'h20, 16'h0042, 512'h2);
      rd(42'h20, 16'h0043, 1'b1);
      drain(10, "collide");
   endtask

   task automatic test_alias();
      wr(42'h405, 16'h0050, {16{32'hDEAD_0405}});
      rd(42'h005, 16'h0051, 1'b1);
      rd(42'h3FF_0000_0005, 16'h0052, 1'b1);
      drain(10, "alias");
   endtask

   task automatic test_almfull_stall();
      int base;
      base = rsp0_cnt;
      rsp_stall = 1'b1;
      for (int i = 0; i < 11; i++) rd(42'h10, 16'(i), 1'b1);
      repeat (3) cyc();
      checks++;
      if ({c0TxAlmFull, c0_rsp_valid} !== 2'b00) begin
         failures++;
         $display("FAIL almfull_below got af=%b v=%b required 0/0 at count 11", c0TxAlmFull, c0_rsp_valid);
      end
      rd(42'h10, 16'd11, 1'b1);
      repeat (2) cyc();
      checks++;
      if ({c0TxAlmFull, c1TxAlmFull} !== 2'b10) begin
         failures++;
         $display("FAIL almfull_at12 got c0af=%b c1af=%b required 1/0", c0TxAlmFull, c1TxAlmFull);
      end
      checks++;
      if (rsp0_cnt != base) begin
         failures++;
         $display("FAIL stall_hold got %0d responses required 0", rsp0_cnt - base);
      end
      rsp_stall = 1'b0;
      repeat (12) cyc();
      checks++;
      if (c0_rsp_valid !== 1'b1) begin
         failures++;
         $display("FAIL burst_12th got v=%b required 1", c0_rsp_valid);
      end
      cyc();
      checks++;
      if (c0_rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL burst_end got v=%b required 0", c0_rsp_valid);
      end
      drain(10, "stall");
      checks++;
      if (rsp0_cnt - base != 12 || c0TxAlmFull !== 1'b0) begin
         failures++;
         $display("FAIL stall_release got %0d rsps af=%b required 12 af=0", rsp0_cnt - base, c0TxAlmFull);
      end
   endtask

   task automatic test_overflow();
      int base;
      base = rsp0_cnt;
      rsp_stall = 1'b1;
      for (int i = 0; i < 16; i++) rd(42'h20, 16'h100 + 16'(i), 1'b1);
      repeat (2) cyc();
      checks++;
      if ({overflow_err, c0TxAlmFull} !== 2'b01) begin
         failures++;
         $display("FAIL full_no_ovf got ovf=%b af=%b required 0/1", overflow_err, c0TxAlmFull);
      end
      for (int i = 16; i < 20; i++) rd(42'h20, 16'h100 + 16'(i), 1'b0);
      repeat (2) cyc();
      checks++;
      if (overflow_err !== 1'b1) begin
         failures++;
         $display("FAIL overflow_set got %b required 1", overflow_err);
      end
      rsp_stall = 1'b0;
      drain(40, "overflow");
      repeat (5) cyc();
      checks++;
      if (rsp0_cnt - base != 16 || overflow_err !== 1'b1) begin
         failures++;
         $display("FAIL overflow_count got %0d rsps ovf=%b required 16 ovf=1", rsp0_cnt - base, overflow_err);
      end
   endtask

   task automatic test_reset_midburst();
      int base;
      rsp_stall = 1'b1;
      for (int i = 0; i < 5; i++) rd(42'h405, 16'h200 + 16'(i), 1'b1);
      repeat (3) cyc();
      rsp_stall = 1'b0;
      cyc();
      cyc();
      #1;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({c0TxAlmFull, c1TxAlmFull, c0_rsp_valid, c0_rsp_mdata, c0_rsp_data,
           c1_rsp_valid, c1_rsp_type, c1_rsp_mdata, overflow_err} !== '0) begin
         failures++;
         $display("FAIL reset_async got v0=%b md0=%h v1=%b t1=%h ovf=%b required all 0",
                  c0_rsp_valid, c0_rsp_mdata, c1_rsp_valid, c1_rsp_type, overflow_err);
      end
      exp0.delete();
      exp1.delete();
      base = rsp0_cnt;
      repeat (2) cyc();
      reset_n = 1'b1;
      repeat (10) cyc();
      checks++;
      if (rsp0_cnt != base) begin
         failures++;
         $display("FAIL reset_discard got %0d responses required 0", rsp0_cnt - base);
      end
      rd(42'h10, 16'h0300, 1'b1);
      rd(42'h005, 16'h0301, 1'b1);
      drain(10, "post_reset");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_same_cycle();
      test_alias();
      test_almfull_stall();
      test_overflow();
      test_reset_midburst();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
